// File: rtl/flex_params_pkg.sv
// flex_params_pkg: counter-width definition shared by the timer and its counter
package flex_params_pkg;
   localparam int NUM_CNT_BITS = 4;
endpackage

// File: rtl/flex_timer_pkg.sv
// flex_timer_pkg: state encoding and default tick-count width for flex_timer_ctrl
package flex_timer_pkg;
   localparam int TICK_W_DEF = 4;
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;
endpackage

// File: rtl/flex_timer_ctrl.sv
// flex_timer_ctrl: runs an external flex_counter for num_ticks rollovers of period clocks each
//   CLK, n_rst        clock, asynchronous active-low reset
//   start, abort      run request (honoured in IDLE only), terminate current run
//   period            counter rollover value, latched in LOAD
//   num_ticks         rollovers per run, latched in LOAD
//   cnt_clear/enable  counter control, Moore decodes of the state
//   cnt_rollover_val  latched period fed to the counter
//   cnt_rollover_flag counter rollover indication
//   tick_strobe       one pulse per rollover while running
//   ticks_done        rollovers completed in the current or last run
//   busy, done        not-idle level, one-cycle completion pulse
module flex_timer_ctrl
   import flex_timer_pkg::*;
#(
   parameter int NUM_CNT_BITS = flex_params_pkg::NUM_CNT_BITS,
   parameter int TICK_W       = TICK_W_DEF
) (
   input  logic                    CLK,
   input  logic                    n_rst,
   input  logic                    start,
   input  logic                    abort,
   input  logic [NUM_CNT_BITS-1:0] period,
   input  logic [TICK_W-1:0]       num_ticks,
   output logic                    cnt_clear,
   output logic                    cnt_enable,
   output logic [NUM_CNT_BITS-1:0] cnt_rollover_val,
   input  logic                    cnt_rollover_flag,
   output logic                    tick_strobe,
   output logic [TICK_W-1:0]       ticks_done,
   output logic                    busy,
   output logic                    done
);
   state_e                  state_q, state_d;
   logic [NUM_CNT_BITS-1:0] rollover_q, rollover_d;
   logic [TICK_W-1:0]       ticks_q, ticks_d, ntick_q, ntick_d, ticks_inc;
   assign ticks_inc = ticks_q + 1'b1;
   always_ff @(posedge CLK or negedge n_rst)
      if (!n_rst) begin
         state_q    <= IDLE;
         rollover_q <= '0;
         ticks_q    <= '0;
         ntick_q    <= '0;
      end else begin
         state_q    <= state_d;
         rollover_q <= rollover_d;
         ticks_q    <= ticks_d;
         ntick_q    <= ntick_d;
      end
   always_comb begin
      state_d    = state_q;
      rollover_d = rollover_q;
      ticks_d    = ticks_q;
      ntick_d    = ntick_q;
      case (state_q)
         IDLE: state_d = (start && !abort) ? LOAD : IDLE;
         LOAD: begin
            rollover_d = period;
            ntick_d    = num_ticks;
            ticks_d    = '0;
            state_d    = abort ? IDLE : (period == '0 || num_ticks == '0) ? DONE : RUN;
         end
         RUN: begin
            // the rollover is counted even when abort wins the state decision
            ticks_d = cnt_rollover_flag ? ticks_inc : ticks_q;
            state_d = abort ? IDLE : (cnt_rollover_flag && ticks_inc == ntick_q) ? DONE : RUN;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   assign cnt_clear        = state_q == LOAD || state_q == DONE;
   assign cnt_enable       = state_q == RUN;
   assign busy             = state_q != IDLE;
   assign done             = state_q == DONE;
   assign tick_strobe      = state_q == RUN && cnt_rollover_flag;
   assign cnt_rollover_val = rollover_q;
   assign ticks_done       = ticks_q;
endmodule

// File: tb/tb_flex_timer_ctrl.sv
// tb_flex_timer_ctrl: directed checks of flex_timer_ctrl against hand-computed timelines
module tb_flex_timer_ctrl;
   logic       CLK = 1'b0;
   logic       n_rst, start, abort;
   logic [3:0] period, num_ticks;
   logic       cnt_clear, cnt_enable, cnt_rollover_flag, tick_strobe, busy, done;
   logic [3:0] cnt_rollover_val, ticks_done;
   logic [4:0] flags;
   int         vecs = 0;
   int         errs = 0;
   int         cnt  = 0;
   always #5 CLK = ~CLK;
   flex_timer_ctrl dut (
      .CLK(CLK), .n_rst(n_rst), .start(start), .abort(abort), .period(period),
      .num_ticks(num_ticks), .cnt_clear(cnt_clear), .cnt_enable(cnt_enable),
      .cnt_rollover_val(cnt_rollover_val), .cnt_rollover_flag(cnt_rollover_flag),
      .tick_strobe(tick_strobe), .ticks_done(ticks_done), .busy(busy), .done(done)
   );
   // counter stand-in: flag is high in every period-th enabled cycle after a clear
   always @(posedge CLK)
      if (cnt_clear) cnt <= 0;
      else if (cnt_enable) cnt <= (cnt + 1 == int'(cnt_rollover_val)) ? 0 : cnt + 1;
   assign cnt_rollover_flag = cnt_enable && (cnt + 1 == int'(cnt_rollover_val));
   // {cnt_clear, cnt_enable, tick_strobe, busy, done}
   assign flags = {cnt_clear, cnt_enable, tick_strobe, busy, done};
   task automatic step();
      @(posedge CLK);
      #1;
   endtask
   task automatic test_reset();
      n_rst = 1'b0; start = 1'b0; abort = 1'b0; period = 4'd0; num_ticks = 4'd0;
      step();
      step();
      vecs++;
      if (flags !== 5'b00000) begin errs++; $display("FAIL reset_flags got %b exp %b", flags, 5'b00000); end
      vecs++;
      if (ticks_done !== 4'd0 || cnt_rollover_val !== 4'd0) begin
         errs++; $display("FAIL reset_vals got ticks=%0d rv=%0d exp 0 0", ticks_done, cnt_rollover_val);
      end
      n_rst = 1'b1;
      step();
      vecs++;
      if (flags !== 5'b00000) begin errs++; $display("FAIL reset_idle got %b exp %b", flags, 5'b00000); end
   endtask
   task automatic test_basic();
      period = 4'd3; num_ticks = 4'd2; start = 1'b1;
      step();
      start = 1'b0;
      vecs++;
      if (flags !== 5'b10010) begin errs++; $display("FAIL basic_load got %b exp %b", flags, 5'b10010); end
      for (int i = 1; i <= 6; i++) begin
         step();
         vecs++;
         if (flags !== ((i % 3 == 0) ? 5'b01110 : 5'b01010)) begin
            errs++; $display("FAIL basic_run%0d got %b exp %b", i, flags, (i % 3 == 0) ? 5'b01110 : 5'b01010);
         end
         vecs++;
         if (ticks_done !== ((i > 3) ? 4'd1 : 4'd0)) begin
            errs++; $display("FAIL basic_ticks%0d got %0d exp %0d", i, ticks_done, (i > 3) ? 1 : 0);
         end
      end
      vecs++;
      if (cnt_rollover_val !== 4'd3) begin errs++; $display("FAIL basic_rv got %0d exp 3", cnt_rollover_val); end
      step();
      vecs++;
      if (flags !== 5'b10011 || ticks_done !== 4'd2) begin
         errs++; $display("FAIL basic_done got %b ticks=%0d exp %b ticks=2", flags, ticks_done, 5'b10011);
      end
      step();
      vecs++;
      if (flags !== 5'b00000 || ticks_done !== 4'd2 || cnt_rollover_val !== 4'd3) begin
         errs++; $display("FAIL basic_hold got %b ticks=%0d rv=%0d exp 00000 2 3", flags, ticks_done, cnt_rollover_val);
      end
   endtask
   task automatic test_zero_ticks();
      for (int k = 0; k < 2; k++) begin
         period = (k == 0) ? 4'd3 : 4'd0; num_ticks = (k == 0) ? 4'd0 : 4'd3; start = 1'b1;
         step();
         start = 1'b0;
         vecs++;
         if (flags !== 5'b10010) begin errs++; $display("FAIL zero%0d_load got %b exp %b", k, flags, 5'b10010); end
         step();
         vecs++;
         if (flags !== 5'b10011 || ticks_done !== 4'd0) begin
            errs++; $display("FAIL zero%0d_done got %b ticks=%0d exp %b ticks=0", k, flags, ticks_done, 5'b10011);
         end
         step();
         vecs++;
         if (flags !== 5'b00000) begin errs++; $display("FAIL zero%0d_idle got %b exp %b", k, flags, 5'b00000); end
      end
   endtask
   task automatic test_abort();
      int dones = 0;
      period = 4'd2; num_ticks = 4'd5; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         step();
         abort = (i == 4);
         vecs++;
         if (flags !== ((i % 2 == 0) ? 5'b01110 : 5'b01010)) begin
            errs++; $display("FAIL abort_run%0d got %b exp %b", i, flags, (i % 2 == 0) ? 5'b01110 : 5'b01010);
         end
      end
      step();
      abort = 1'b0;
      vecs++;
      if (flags !== 5'b00000 || ticks_done !== 4'd2) begin
         errs++; $display("FAIL abort_idle got %b ticks=%0d exp 00000 ticks=2", flags, ticks_done);
      end
      for (int i = 0; i < 3; i++) begin step(); dones += done; end
      vecs++;
      if (dones !== 0 || ticks_done !== 4'd2) begin
         errs++; $display("FAIL abort_hold got dones=%0d ticks=%0d exp 0 2", dones, ticks_done);
      end
      // abort beats the final tick; start with abort in IDLE is refused
      period = 4'd1; num_ticks = 4'd1; start = 1'b1;
      step();
      start = 1'b0;
      step();
      abort = 1'b1;
      vecs++;
      if (flags !== 5'b01110) begin errs++; $display("FAIL abort_final_run got %b exp %b", flags, 5'b01110); end
      start = 1'b1;
      step();
      vecs++;
      if (flags !== 5'b00000 || ticks_done !== 4'd1) begin
         errs++; $display("FAIL abort_final got %b ticks=%0d exp 00000 ticks=1", flags, ticks_done);
      end
      step();
      vecs++;
      if (flags !== 5'b00000) begin errs++; $display("FAIL abort_start_idle got %b exp %b", flags, 5'b00000); end
      start = 1'b0; abort = 1'b0;
   endtask
   task automatic test_back_to_back();
      int dones = 0;
      period = 4'd4; num_ticks = 4'd1; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         step();
         start = (i == 2);
         vecs++;
         if (flags !== ((i == 4) ? 5'b01110 : 5'b01010)) begin
            errs++; $display("FAIL b2b_run%0d got %b exp %b", i, flags, (i == 4) ? 5'b01110 : 5'b01010);
         end
      end
      for (int i = 0; i < 6; i++) begin step(); dones += done; end
      vecs++;
      if (dones !== 1 || busy !== 1'b0 || ticks_done !== 4'd1) begin
         errs++; $display("FAIL b2b_single got dones=%0d busy=%b ticks=%0d exp 1 0 1", dones, busy, ticks_done);
      end
   endtask
   task automatic test_reset_mid_run();
      period = 4'd5; num_ticks = 4'd2; start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      vecs++;
      if (flags !== 5'b01010) begin errs++; $display("FAIL rst_run got %b exp %b", flags, 5'b01010); end
      n_rst = 1'b0;
      #1;
      vecs++;
      if (flags !== 5'b00000 || ticks_done !== 4'd0 || cnt_rollover_val !== 4'd0) begin
         errs++; $display("FAIL rst_async got %b ticks=%0d rv=%0d exp 00000 0 0", flags, ticks_done, cnt_rollover_val);
      end
      step();
      n_rst = 1'b1;
      period = 4'd2; num_ticks = 4'd1; start = 1'b1;
      step();
      start = 1'b0;
      vecs++;
      if (flags !== 5'b10010) begin errs++; $display("FAIL rst_restart got %b exp %b", flags, 5'b10010); end
      step();
      step();
      vecs++;
      if (flags !== 5'b01110) begin errs++; $display("FAIL rst_tick got %b exp %b", flags, 5'b01110); end
      step();
      vecs++;
      if (flags !== 5'b10011 || ticks_done !== 4'd1) begin
         errs++; $display("FAIL rst_done got %b ticks=%0d exp %b ticks=1", flags, ticks_done, 5'b10011);
      end
   endtask
   initial begin
      test_reset();
      test_basic();
      test_zero_ticks();
      test_abort();
      test_back_to_back();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/flex_timer_ctrl.md
FLEX_TIMER_CTRL -- requirements
Module: flex_timer_ctrl

Interface
REQ-001 Parameter NUM_CNT_BITS, default 4: width of the counter value fields; SHALL equal the shared counter-width definition.
REQ-002 Parameter TICK_W, default 4: width of the tick-count fields.
REQ-003 CLK  in  1  single clock; all state updates on posedge.
REQ-004 n_rst  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  run request, sampled in IDLE only.
REQ-006 abort  in  1  terminate the current run.
REQ-007 period  in  NUM_CNT_BITS  rollover value per tick; 1..2^N-1 is legal.
REQ-008 num_ticks  in  TICK_W  rollovers per run.
REQ-009 cnt_clear  out  1  drives the counter's clear input.
REQ-010 cnt_enable  out  1  drives the counter's count_enable input.
REQ-011 cnt_rollover_val  out  NUM_CNT_BITS  drives the counter's rollover_val input.
REQ-012 cnt_rollover_flag  in  1  the counter's rollover_flag output.
REQ-013 tick_strobe  out  1  one-cycle pulse per counter rollover.
REQ-014 ticks_done  out  TICK_W  number of ticks completed in the current or last run.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 done  out  1  one-cycle completion pulse.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, LOAD, RUN, DONE.
REQ-018 IDLE->LOAD on start=1 and abort=0; otherwise the FSM SHALL stay in IDLE.
REQ-019 LOAD lasts one cycle and SHALL perform the following: cnt_clear=1; latch period into cnt_rollover_val; latch num_ticks internally; ticks_done<=0.
REQ-020 LOAD->DONE if the latched period==0 or num_ticks==0 (zero-tick run); otherwise LOAD->RUN.
REQ-021 In RUN, cnt_enable SHALL be 1 and tick_strobe SHALL equal cnt_rollover_flag, combinationally.
REQ-022 Each RUN cycle with cnt_rollover_flag=1 SHALL increment ticks_done by 1.
REQ-023 RUN->DONE in the cycle where the flag is 1 and ticks_done+1 equals the latched num_ticks.
REQ-024 DONE lasts one cycle and SHALL perform the following: done=1, cnt_clear=1, cnt_enable=0; then the FSM SHALL go to IDLE.
REQ-025 abort=1 in LOAD, RUN or DONE SHALL force the next state to IDLE with no done pulse; abort SHALL take priority over a final tick in the same cycle.
REQ-026 start while busy=1 SHALL be ignored; it is not queued.
REQ-027 ticks_done and cnt_rollover_val SHALL hold their values in IDLE until the next LOAD.
REQ-028 With period=P and num_ticks=T, the first tick_strobe SHALL occur in the P-th RUN cycle and done SHALL occur 2+P*T cycles after the start-sampling edge.
REQ-029 cnt_clear, cnt_enable, busy and done SHALL be Moore decodes of the state register; they are 0 in IDLE.

Reset
REQ-030 n_rst=0 SHALL asynchronously force the following: state=IDLE; cnt_rollover_val=0; ticks_done=0; all 1-bit outputs 0 (tick_strobe=0 because state is not RUN).
REQ-031 Reset asserted mid-run SHALL abandon the run with no done pulse.
REQ-032 After reset release, the first start SHALL be honoured on the first posedge.

Structure
REQ-033 Package flex_timer_pkg SHALL hold the state enum and the TICK_W default; NUM_CNT_BITS SHALL come from the shared parameter definitions.
REQ-034 The block SHALL contain no sub-module; flex_counter SHALL be instantiated alongside it in a wrapper, flex_timer_top, connecting the cnt_* ports.

Verification
REQ-035 Reset sequence: n_rst low for 2 cycles -> all outputs 0, busy=0.
REQ-036 period=3, num_ticks=2, start pulse -> LOAD with cnt_clear=1; tick_strobe in RUN cycles 3 and 6; ticks_done=2; done 8 cycles after start; busy falls the next cycle.
REQ-037 num_ticks=0, start -> done 2 cycles after start; ticks_done=0; no tick_strobe.
REQ-038 period=2, num_ticks=5, abort asserted in RUN cycle 4 -> IDLE next cycle, no done, ticks_done=2 held.
REQ-039 start re-pulsed during RUN with period=4, num_ticks=1 -> single done; no second run begins.
REQ-040 n_rst asserted mid-RUN with period=5 -> immediate IDLE, cnt_enable=0; a fresh start completes normally.
